// File: rtl/sc_bus_pkg.sv
// Shared definitions for the single-cycle computer data-memory bus.
package sc_bus_pkg;

    // Arbiter FSM state encoding.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } arb_state_e;

    // Master port identifiers.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    // Default bus geometry.
    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_RD_LAT = 2;

    // Wide enough for the largest legal read latency (15).
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/sc_rr_pick2.sv
// Two-way round-robin pick: on a tie the port not granted last wins.
module sc_rr_pick2
    import sc_bus_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       winner_o,
    output logic       valid_o
);

    // Single requester wins outright; a tie goes to the other port than last time.
    always_comb begin
        valid_o  = |req_i;
        winner_o = PORT_CPU;
        unique case (req_i)
            2'b01:   winner_o = PORT_CPU;
            2'b10:   winner_o = PORT_AUX;
            2'b11:   winner_o = ~last_grant_i;
            default: winner_o = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/sc_dmem_arbiter.sv
// Round-robin arbiter sharing the dmem/IO bus between the CPU port and the aux port.
// One transaction in flight at a time; responses return after a fixed read latency.
module sc_dmem_arbiter
    import sc_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] WaitLoad = CNT_W'(RD_LAT - 1);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic pick_winner;
    logic pick_valid;

    sc_rr_pick2 u_pick (
        .req_i        ({m1_req, m0_req}),
        .last_grant_i (last_q),
        .winner_o     (pick_winner),
        .valid_o      (pick_valid)
    );

    // Next-state: arbitrate in IDLE/RESP, strobe in ISSUE, count down in WAIT.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            StIdle, StResp: begin
                if (pick_valid) begin
                    state_d = StIssue;
                    owner_d = pick_winner;
                    we_d    = (pick_winner == PORT_AUX) ? m1_we    : m0_we;
                    addr_d  = (pick_winner == PORT_AUX) ? m1_addr  : m0_addr;
                    wdata_d = (pick_winner == PORT_AUX) ? m1_wdata : m0_wdata;
                end else begin
                    state_d = StIdle;
                end
            end
            StIssue: begin
                state_d = StWait;
                cnt_d   = WaitLoad;
                last_d  = owner_q;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    // Last WAIT cycle is exactly when read data is valid on the bus.
                    if (!we_q) begin
                        if (owner_q == PORT_AUX) begin
                            rdata1_d = mem_rdata;
                        end else begin
                            rdata0_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset aborts any in-flight transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            owner_q  <= PORT_CPU;
            we_q     <= 1'b0;
            last_q   <= PORT_AUX;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        mem_en    = (state_q == StIssue);
        mem_we    = mem_en && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        m0_gnt    = mem_en && (owner_q == PORT_CPU);
        m1_gnt    = mem_en && (owner_q == PORT_AUX);
        m0_rvalid = (state_q == StResp) && (owner_q == PORT_CPU);
        m1_rvalid = (state_q == StResp) && (owner_q == PORT_AUX);
        m0_rdata  = rdata0_q;
        m1_rdata  = rdata1_q;
        busy      = (state_q == StIssue) || (state_q == StWait);
    end

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// Directed self-checking bench: one arbiter built with RD_LAT=2, one with RD_LAT=1.
module tb_sc_dmem_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    // RD_LAT=2 instance signals
    logic        a_m0_req = 0, a_m0_we = 0, a_m1_req = 0, a_m1_we = 0;
    logic [31:0] a_m0_addr = 0, a_m0_wdata = 0, a_m1_addr = 0, a_m1_wdata = 0;
    logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_en, a_mem_we, a_busy;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

    // RD_LAT=1 instance signals
    logic        b_m0_req = 0, b_m0_we = 0, b_m1_req = 0, b_m1_we = 0;
    logic [31:0] b_m0_addr = 0, b_m0_wdata = 0, b_m1_addr = 0, b_m1_wdata = 0;
    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    sc_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) dut_a (
        .clock(clock), .reset(reset),
        .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
        .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    sc_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut_b (
        .clock(clock), .reset(reset),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory contents as a fixed function of address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    // Memory models: data is valid only in the cycle RD_LAT after a read strobe.
    logic [1:0]  a_pv = 2'b00;
    logic [31:0] a_pd0 = 0, a_pd1 = 0;
    logic        b_pv = 1'b0;
    logic [31:0] b_pd = 0;

    always @(posedge clock) begin
        a_pv  <= {a_pv[0], a_mem_en & ~a_mem_we};
        a_pd0 <= mem_f(a_mem_addr);
        a_pd1 <= a_pd0;
        b_pv  <= b_mem_en & ~b_mem_we;
        b_pd  <= mem_f(b_mem_addr);
    end

    assign a_mem_rdata = a_pv[1] ? a_pd1 : 32'hBAD0BAD0;
    assign b_mem_rdata = b_pv ? b_pd : 32'hBAD0BAD0;

    // {m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_en, mem_we, busy}
    wire [6:0] a_flags = {a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_en, a_mem_we, a_busy};
    wire [6:0] b_flags = {b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_en, b_mem_we, b_busy};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int n0, n1, bad_alt, bad_gap, both, last_port, last_cyc, first_port, first_cyc, p, cnt_rv, cnt_en;

    initial begin
        // Reset state
        tick();
        tick();
        check_eq("rst_flags", a_flags, 7'b0);
        check_eq("rst_mem_addr", a_mem_addr, 32'h0);
        check_eq("rst_mem_wdata", a_mem_wdata, 32'h0);
        check_eq("rst_m0_rdata", a_m0_rdata, 32'h0);
        check_eq("rst_m1_rdata", a_m1_rdata, 32'h0);
        check_eq("rst_b_flags", b_flags, 7'b0);
        reset = 1'b0;

        // Single read from m0
        a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h10;
        check_eq("rd_c0_gnt", a_m0_gnt, 1'b0);
        tick();
        check_eq("rd_c1_flags", a_flags, 7'b1000101);
        check_eq("rd_c1_addr", a_mem_addr, 32'h10);
        a_m0_req = 0;
        tick();
        check_eq("rd_c2_flags", a_flags, 7'b0000001);
        tick();
        check_eq("rd_c3_flags", a_flags, 7'b0000001);
        tick();
        check_eq("rd_c4_flags", a_flags, 7'b0100000);
        check_eq("rd_c4_rdata", a_m0_rdata, 32'hDEADBEEF);
        tick();
        check_eq("rd_c5_flags", a_flags, 7'b0);
        check_eq("rd_c5_rdata_hold", a_m0_rdata, 32'hDEADBEEF);

        // Tie after reset: m0 first, m1 arbitrated in RESP
        reset = 1; tick(); reset = 0;
        a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h100;
        a_m1_req = 1; a_m1_we = 0; a_m1_addr = 32'h200;
        tick();
        check_eq("tie_c1_gnt", {a_m0_gnt, a_m1_gnt}, 2'b10);
        check_eq("tie_c1_addr", a_mem_addr, 32'h100);
        a_m0_req = 0;
        tick(); tick(); tick();
        check_eq("tie_c4_rv", {a_m0_rvalid, a_m1_gnt}, 2'b10);
        check_eq("tie_c4_rdata", a_m0_rdata, mem_f(32'h100));
        tick();
        check_eq("tie_c5_gnt", {a_m0_gnt, a_m1_gnt}, 2'b01);
        check_eq("tie_c5_addr", a_mem_addr, 32'h200);
        a_m1_req = 0;
        tick(); tick(); tick();
        check_eq("tie_c8_rv", {a_m0_rvalid, a_m1_rvalid}, 2'b01);
        check_eq("tie_c8_rdata", a_m1_rdata, mem_f(32'h200));
        tick();

        // Continuous contention for 10 transactions
        reset = 1; tick(); reset = 0;
        a_m0_req = 1; a_m0_addr = 32'h300;
        a_m1_req = 1; a_m1_addr = 32'h400;
        n0 = 0; n1 = 0; bad_alt = 0; bad_gap = 0; both = 0;
        last_port = -1; last_cyc = 0; first_port = -1; first_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (a_m0_gnt && a_m1_gnt) both++;
            if (a_m0_gnt || a_m1_gnt) begin
                p = a_m1_gnt ? 1 : 0;
                if (p == 0) n0++; else n1++;
                if (last_port >= 0) begin
                    if (p == last_port) bad_alt++;
                    if (c - last_cyc != 4) bad_gap++;
                end else begin
                    first_port = p;
                    first_cyc  = c;
                end
                last_port = p;
                last_cyc  = c;
            end
        end
        check_eq("cont_n0", n0, 5);
        check_eq("cont_n1", n1, 5);
        check_eq("cont_alternate", bad_alt, 0);
        check_eq("cont_spacing", bad_gap, 0);
        check_eq("cont_both_gnt", both, 0);
        check_eq("cont_first_port", first_port, 0);
        check_eq("cont_first_cyc", first_cyc, 1);
        check_eq("cont_last_cyc", last_cyc, 37);
        check_eq("cont_c40_rv", a_m1_rvalid, 1'b1);
        check_eq("cont_m1_rdata", a_m1_rdata, mem_f(32'h400));
        check_eq("cont_m0_rdata", a_m0_rdata, mem_f(32'h300));
        a_m0_req = 0; a_m1_req = 0;
        tick();
        check_eq("cont_idle_flags", a_flags, 7'b0);

        // Write from m1
        a_m1_req = 1; a_m1_we = 1; a_m1_addr = 32'h20; a_m1_wdata = 32'h12345678;
        tick();
        check_eq("wr_c1_flags", a_flags, 7'b0010111);
        check_eq("wr_c1_addr", a_mem_addr, 32'h20);
        check_eq("wr_c1_wdata", a_mem_wdata, 32'h12345678);
        a_m1_req = 0; a_m1_we = 0;
        tick();
        check_eq("wr_c2_flags", a_flags, 7'b0000001);
        check_eq("wr_c2_addr_hold", a_mem_addr, 32'h20);
        check_eq("wr_c2_wdata_hold", a_mem_wdata, 32'h12345678);
        tick(); tick();
        check_eq("wr_c4_flags", a_flags, 7'b0001000);
        check_eq("wr_c4_rdata_kept", a_m1_rdata, mem_f(32'h400));
        tick();

        // Reset during WAIT aborts the read
        a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h30;
        tick();
        check_eq("abort_c1_gnt", a_m0_gnt, 1'b1);
        a_m0_req = 0;
        tick();
        reset = 1;
        tick();
        check_eq("abort_flags", a_flags, 7'b0);
        check_eq("abort_mem_addr", a_mem_addr, 32'h0);
        check_eq("abort_m0_rdata", a_m0_rdata, 32'h0);
        reset = 0;
        cnt_rv = 0; cnt_en = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (a_m0_rvalid) cnt_rv++;
            if (a_mem_en) cnt_en++;
        end
        check_eq("abort_no_rvalid", cnt_rv, 0);
        check_eq("abort_no_mem_en", cnt_en, 0);
        a_m0_req = 1; a_m1_req = 1; a_m0_addr = 32'h34; a_m1_addr = 32'h38;
        tick();
        check_eq("abort_tie_gnt", {a_m0_gnt, a_m1_gnt}, 2'b10);
        a_m0_req = 0; a_m1_req = 0;
        tick(); tick(); tick(); tick();

        // RD_LAT=1: single read
        b_m0_req = 1; b_m0_we = 0; b_m0_addr = 32'h40;
        tick();
        check_eq("l1_c1_flags", b_flags, 7'b1000101);
        b_m0_req = 0;
        tick();
        check_eq("l1_c2_flags", b_flags, 7'b0000001);
        tick();
        check_eq("l1_c3_flags", b_flags, 7'b0100000);
        check_eq("l1_c3_rdata", b_m0_rdata, mem_f(32'h40));
        tick();

        // RD_LAT=1: back-to-back m0 requests
        b_m0_req = 1; b_m0_addr = 32'h50;
        n0 = 0; bad_gap = 0; last_cyc = -1; first_cyc = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (b_m0_gnt) begin
                n0++;
                if (last_cyc >= 0) begin
                    if (c - last_cyc != 3) bad_gap++;
                end else begin
                    first_cyc = c;
                end
                last_cyc = c;
            end
        end
        check_eq("l1_b2b_count", n0, 4);
        check_eq("l1_b2b_spacing", bad_gap, 0);
        check_eq("l1_b2b_first", first_cyc, 1);
        check_eq("l1_b2b_rdata", b_m0_rdata, mem_f(32'h50));
        b_m0_req = 0;
        tick();
        check_eq("l1_idle_flags", b_flags, 7'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
